ext_slow_mem_arbiter: RTL and testbench

EXT_SLOW_MEM_ARBITER -- requirements
Module: ext_slow_mem_arbiter

---
 rtl/ext_slow_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ext_slow_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_slow_mem_arbiter.sv
// Round-robin arbiter that lets NMASTER OBI requesters share one slow external slave.
// Keeps one transaction in flight; addresses outside the window and slave timeouts get an error response.
module ext_slow_mem_arbiter #(
    parameter int          NMASTER    = 4,
    parameter logic [31:0] START_ADDR = 32'h2000_0000, // platform EXT_SLAVE_START_ADDRESS
    parameter logic [31:0] SIZE       = 32'h400,
    parameter int          TIMEOUT    = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NMASTER-1:0]        m_req_i,
    input  logic [NMASTER-1:0]        m_we_i,
    input  logic [NMASTER-1:0][3:0]   m_be_i,
    input  logic [NMASTER-1:0][31:0]  m_addr_i,
    input  logic [NMASTER-1:0][31:0]  m_wdata_i,
    output logic [NMASTER-1:0]        m_gnt_o,
    output logic [NMASTER-1:0]        m_rvalid_o,
    output logic [NMASTER-1:0]        m_err_o,
    output logic [NMASTER-1:0][31:0]  m_rdata_o,
    output logic                      s_req_o,
    output logic                      s_we_o,
    output logic [3:0]                s_be_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    input  logic                      s_gnt_i,
    input  logic                      s_rvalid_i,
    input  logic [31:0]               s_rdata_i,
    output logic                      timeout_o
);
    localparam int PW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam logic [31:0] ERR_DATA = 32'hBADC_AB1E;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, HOLD, WAIT_R, ERR} state_e;

    state_e      state_q, state_d;
    ptr_t        rr_q, rr_d, owner_q, owner_d, sel, idx;
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;
    logic        any_req, sel_in_win;

    logic [NMASTER-1:0]       gnt, rvalid, err;
    logic [NMASTER-1:0][31:0] rdata;
    logic                     sreq, swe;
    logic [3:0]               sbe;
    logic [31:0]              saddr, swdata;

    function automatic ptr_t inc(input ptr_t p);
        return (p == ptr_t'(NMASTER - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Scan from the highest offset down so the requester nearest rr_q wins.
    always_comb begin
        sel     = rr_q;
        any_req = 1'b0;
        idx     = '0;
        for (int i = NMASTER - 1; i >= 0; i--) begin
            idx = ptr_t'((int'(rr_q) + i) % NMASTER);
            if (m_req_i[idx]) begin
                sel     = idx;
                any_req = 1'b1;
            end
        end
    end

    assign sel_in_win = ({1'b0, m_addr_i[sel]} >= {1'b0, START_ADDR}) &&
                        ({1'b0, m_addr_i[sel]} <  ({1'b0, START_ADDR} + {1'b0, SIZE}));

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        gnt     = '0;
        rvalid  = '0;
        err     = '0;
        rdata   = '0;
        sreq    = 1'b0;
        swe     = 1'b0;
        sbe     = '0;
        saddr   = '0;
        swdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = sel;
                    if (sel_in_win) begin
                        sreq   = 1'b1;
                        swe    = m_we_i[sel];
                        sbe    = m_be_i[sel];
                        saddr  = m_addr_i[sel];
                        swdata = m_wdata_i[sel];
                        if (s_gnt_i) begin
                            gnt[sel] = 1'b1;
                            rr_d     = inc(sel);
                            cnt_d    = '0;
                            state_d  = WAIT_R;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        gnt[sel] = 1'b1;
                        rr_d     = inc(sel);
                        state_d  = ERR;
                    end
                end
            end
            HOLD: begin
                // Owner stays locked even if it drops its request.
                sreq   = 1'b1;
                swe    = m_we_i[owner_q];
                sbe    = m_be_i[owner_q];
                saddr  = m_addr_i[owner_q];
                swdata = m_wdata_i[owner_q];
                if (s_gnt_i) begin
                    gnt[owner_q] = 1'b1;
                    rr_d         = inc(owner_q);
                    cnt_d        = '0;
                    state_d      = WAIT_R;
                end
            end
            WAIT_R: begin
                if (s_rvalid_i) begin
                    rvalid[owner_q] = 1'b1;
                    rdata[owner_q]  = s_rdata_i;
                    cnt_d           = '0;
                    state_d         = IDLE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ERR: begin
                rvalid[owner_q] = 1'b1;
                err[owner_q]    = 1'b1;
                rdata[owner_q]  = ERR_DATA;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // IDLE decode is combinational from the masters, so hold every output low during reset.
    assign m_gnt_o    = rst_ni ? gnt    : '0;
    assign m_rvalid_o = rst_ni ? rvalid : '0;
    assign m_err_o    = rst_ni ? err    : '0;
    assign m_rdata_o  = rst_ni ? rdata  : '0;
    assign s_req_o    = rst_ni & sreq;
    assign s_we_o     = rst_ni & swe;
    assign s_be_o     = rst_ni ? sbe    : '0;
    assign s_addr_o   = rst_ni ? saddr  : '0;
    assign s_wdata_o  = rst_ni ? swdata : '0;
    assign timeout_o  = to_q;

endmodule

// File: tb/tb_ext_slow_mem_arbiter.sv
// Scoreboard bench for ext_slow_mem_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT asserts m_gnt_o or m_rvalid_o.
module tb_ext_slow_mem_arbiter;
    localparam int          NM   = 4;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] ERRD = 32'hBADC_AB1E;

    typedef struct {
        int          idx;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic [NM-1:0]       m_req_i, m_we_i;
    logic [NM-1:0][3:0]  m_be_i;
    logic [NM-1:0][31:0] m_addr_i, m_wdata_i;
    logic [NM-1:0]       m_gnt_o, m_rvalid_o, m_err_o;
    logic [NM-1:0][31:0] m_rdata_o;
    logic                s_req_o, s_we_o;
    logic [3:0]          s_be_o;
    logic [31:0]         s_addr_o, s_wdata_o;
    logic                s_gnt_i, s_rvalid_i;
    logic [31:0]         s_rdata_i;
    logic                timeout_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_gnt[$];
    rsp_t exp_rsp[$];
    int   mon_gi;
    rsp_t mon_r;
    logic [NM-1:0][31:0] mon_ev;

    ext_slow_mem_arbiter #(
        .NMASTER(NM), .START_ADDR(BASE), .SIZE(32'h400), .TIMEOUT(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input int i, input bit e, input logic [31:0] d);
        rsp_t r;
        r.idx = i; r.err = e; r.data = d;
        exp_rsp.push_back(r);
    endtask

    always @(negedge clk) begin
        if (m_gnt_o != '0) begin
            if (exp_gnt.size() == 0) check("unexpected_gnt", 128'(m_gnt_o), 128'd0);
            else begin
                mon_gi = exp_gnt.pop_front();
                check("gnt", 128'(m_gnt_o), 128'(4'b0001 << mon_gi));
            end
        end
        if (m_rvalid_o != '0) begin
            if (exp_rsp.size() == 0) check("unexpected_rvalid", 128'(m_rvalid_o), 128'd0);
            else begin
                mon_r  = exp_rsp.pop_front();
                mon_ev = '0;
                mon_ev[mon_r.idx] = mon_r.data;
                check("rvalid", 128'(m_rvalid_o), 128'(4'b0001 << mon_r.idx));
                check("err", 128'(m_err_o), mon_r.err ? 128'(4'b0001 << mon_r.idx) : 128'd0);
                check("rdata", m_rdata_o, mon_ev);
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        m_req_i = '0; m_we_i = '0; m_be_i = {NM{4'hF}};
        m_addr_i = '0; m_wdata_i = '0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        @(negedge clk);
        check("reset_outputs", 128'({m_gnt_o, m_rvalid_o, m_err_o, s_req_o, timeout_o}), 128'd0);
        #2 rst_ni = 1'b1;
        tick;

        // Contention: all four request, expect 0,1,2,3,0
        for (int i = 0; i < NM; i++) m_addr_i[i] = BASE + 32'(4 * i);
        m_req_i = 4'b1111; s_gnt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt.push_back(k % 4);
            push_rsp(k % 4, 1'b0, 32'hA000_0000 + 32'(k));
            s_rvalid_i = 1'b0;
            tick;
            s_rvalid_i = 1'b1; s_rdata_i = 32'hA000_0000 + 32'(k);
            tick;
        end
        m_req_i = '0; s_rvalid_i = 1'b0; s_gnt_i = 1'b0;
        tick;

        // Single read from master 1
        m_req_i = 4'b0010; m_addr_i[1] = BASE + 32'h8; s_gnt_i = 1'b1;
        exp_gnt.push_back(1);
        @(negedge clk);
        check("single_sreq_addr", 128'({s_req_o, s_addr_o}), 128'({1'b1, BASE + 32'h8}));
        tick;
        m_req_i = '0; s_gnt_i = 1'b0;
        tick;
        push_rsp(1, 1'b0, 32'h1234_5678);
        s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
        tick;
        s_rvalid_i = 1'b0; s_rdata_i = '0;
        tick;

        // Backpressure: master 3 held in HOLD, master 0 arrives meanwhile
        m_req_i = 4'b1000; m_addr_i[3] = BASE + 32'h3C; m_we_i[3] = 1'b1;
        m_be_i[3] = 4'b1100; m_wdata_i[3] = 32'hDEAD_BEEF; s_gnt_i = 1'b0;
        exp_gnt.push_back(3);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin m_req_i[0] = 1'b1; m_addr_i[0] = BASE + 32'h10; end
            if (c == 3) s_gnt_i = 1'b1;
            @(negedge clk);
            check("hold_slave_req", 128'({s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o}),
                  128'({1'b1, 1'b1, 4'b1100, BASE + 32'h3C, 32'hDEAD_BEEF}));
            tick;
        end
        m_req_i[3] = 1'b0; s_gnt_i = 1'b0;
        push_rsp(3, 1'b0, 32'h0);
        s_rvalid_i = 1'b1; s_rdata_i = '0;
        tick;
        s_rvalid_i = 1'b0; s_gnt_i = 1'b1;
        exp_gnt.push_back(0);
        tick;
        m_req_i[0] = 1'b0; s_gnt_i = 1'b0;
        push_rsp(0, 1'b0, 32'h55);
        s_rvalid_i = 1'b1; s_rdata_i = 32'h55;
        tick;
        s_rvalid_i = 1'b0; m_we_i = '0; m_be_i = {NM{4'hF}};
        tick;

        // Out of window, upper edge
        m_req_i = 4'b0100; m_addr_i[2] = BASE + 32'h400; s_gnt_i = 1'b1;
        exp_gnt.push_back(2);
        push_rsp(2, 1'b1, ERRD);
        @(negedge clk);
        check("oow_sreq_c0", 128'(s_req_o), 128'd0);
        tick;
        m_req_i = '0; s_gnt_i = 1'b0;
        @(negedge clk);
        check("oow_sreq_c1", 128'(s_req_o), 128'd0);
        tick;
        tick;

        // Out of window, lower edge
        m_req_i = 4'b1000; m_addr_i[3] = BASE - 32'h4;
        exp_gnt.push_back(3);
        push_rsp(3, 1'b1, ERRD);
        tick;
        m_req_i = '0;
        tick;
        tick;

        // Timeout with top in-window address
        m_req_i = 4'b1000; m_addr_i[3] = BASE + 32'h3FC; s_gnt_i = 1'b1;
        exp_gnt.push_back(3);
        tick;
        m_req_i = '0; s_gnt_i = 1'b0;
        tick;
        tick;
        tick;
        @(negedge clk);
        check("timeout_before", 128'(timeout_o), 128'd0);
        tick;
        push_rsp(3, 1'b1, ERRD);
        tick;
        s_rvalid_i = 1'b1; s_rdata_i = 32'h77;
        @(negedge clk);
        check("late_rvalid_dropped", 128'({m_rvalid_o, timeout_o}), 128'({4'b0000, 1'b1}));
        tick;
        s_rvalid_i = 1'b0; s_rdata_i = '0;
        tick;
        tick;
        @(negedge clk);
        check("timeout_sticky", 128'(timeout_o), 128'd1);
        tick;

        // Reset during WAIT_R
        m_req_i = 4'b0010; m_addr_i[1] = BASE + 32'h20; s_gnt_i = 1'b1;
        exp_gnt.push_back(1);
        tick;
        m_req_i = '0; s_gnt_i = 1'b0;
        tick;
        rst_ni = 1'b0;
        m_req_i = 4'b0100; m_addr_i[2] = BASE + 32'h24; s_gnt_i = 1'b1;
        @(negedge clk);
        check("rst_ctrl_outputs", 128'({m_gnt_o, m_rvalid_o, m_err_o, s_req_o, s_we_o, s_be_o, timeout_o}),
              128'd0);
        check("rst_data_outputs", 128'({m_rdata_o[0] | m_rdata_o[1] | m_rdata_o[2] | m_rdata_o[3],
                                        s_addr_o, s_wdata_o}), 128'd0);
        tick;
        rst_ni = 1'b1;
        m_req_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h99;
        @(negedge clk);
        check("stale_rvalid_dropped", 128'(m_rvalid_o), 128'd0);
        tick;
        s_rvalid_i = 1'b0; m_req_i = 4'b0101; m_addr_i[0] = BASE + 32'h28; s_gnt_i = 1'b1;
        exp_gnt.push_back(0);
        tick;
        m_req_i = 4'b0100; s_gnt_i = 1'b0;
        push_rsp(0, 1'b0, 32'h11);
        s_rvalid_i = 1'b1; s_rdata_i = 32'h11;
        tick;
        s_rvalid_i = 1'b0; s_gnt_i = 1'b1;
        exp_gnt.push_back(2);
        tick;
        m_req_i = '0; s_gnt_i = 1'b0;
        push_rsp(2, 1'b0, 32'h22);
        s_rvalid_i = 1'b1; s_rdata_i = 32'h22;
        tick;
        s_rvalid_i = 1'b0; s_rdata_i = '0;
        tick;
        tick;

        check("gnt_queue_drained", 128'(exp_gnt.size()), 128'd0);
        check("rsp_queue_drained", 128'(exp_rsp.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
